// File: rtl/dram_arbiter.sv
// Two-requester arbiter for a single-port 256 KB data memory.
// Round-robin or fixed priority with IDLE/ISSUE/WAIT sequencing.
module dram_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int FIXED_PRIO   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [17:0] addr0,
  input  logic [17:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        busy,
  output logic [17:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_wren,
  input  logic [7:0]  mem_q
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic       RR       = (FIXED_PRIO == 0);
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        sel_q, sel_d;
  logic        wr_q, wr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        pick1;

  // Requester 1 wins alone, or on a tie when requester 0 went last.
  assign pick1 = req1 && (!req0 || (RR && !last_q));

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel_d   = pick1;
          last_d  = pick1;
          addr_d  = pick1 ? addr1 : addr0;
          data_d  = pick1 ? wdata1 : wdata0;
          wr_d    = pick1 ? we1 : we0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
          if (sel_q) begin
            rvalid1_d = 1'b1;
            rdata1_d  = mem_q;
          end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = mem_q;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= 2'd0;
      addr_q    <= 18'd0;
      data_q    <= 8'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 8'd0;
      rdata1_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign gnt0        = (state_q == ISSUE) && !sel_q;
  assign gnt1        = (state_q == ISSUE) && sel_q;
  assign mem_wren    = (state_q == ISSUE) && wr_q;
  assign busy        = (state_q != IDLE);
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: RR/latency-1 and fixed/latency-3
// instances share stimulus, each with its own memory model.
module tb_dram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req0, req1, we0, we1;
  logic [17:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;

  logic        ga0, ga1, va0, va1, busy_a, wren_a;
  logic [7:0]  qa0, qa1, mdata_a, q_a;
  logic [17:0] maddr_a;
  logic        gb0, gb1, vb0, vb1, busy_b, wren_b;
  logic [7:0]  qb0, qb1, mdata_b, q_b;
  logic [17:0] maddr_b;

  dram_arbiter #(.READ_LATENCY(1), .FIXED_PRIO(0)) dut_a (
    .clock(clk), .reset(rst), .req0(req0), .req1(req1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(ga0), .gnt1(ga1),
    .rvalid0(va0), .rvalid1(va1), .rdata0(qa0), .rdata1(qa1),
    .busy(busy_a), .mem_address(maddr_a), .mem_data(mdata_a),
    .mem_wren(wren_a), .mem_q(q_a)
  );

  dram_arbiter #(.READ_LATENCY(3), .FIXED_PRIO(1)) dut_b (
    .clock(clk), .reset(rst), .req0(req0), .req1(req1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gb0), .gnt1(gb1),
    .rvalid0(vb0), .rvalid1(vb1), .rdata0(qb0), .rdata1(qb1),
    .busy(busy_b), .mem_address(maddr_b), .mem_data(mdata_b),
    .mem_wren(wren_b), .mem_q(q_b)
  );

  // Synchronous RAMs: one-stage read for a, three-stage for b.
  logic [7:0] mem_a [0:262143];
  logic [7:0] mem_b [0:262143];
  logic [7:0] pb0, pb1;

  always @(posedge clk) begin
    if (wren_a) mem_a[maddr_a] <= mdata_a;
    q_a <= mem_a[maddr_a];
  end

  always @(posedge clk) begin
    if (wren_b) mem_b[maddr_b] <= mdata_b;
    pb0 <= mem_b[maddr_b];
    pb1 <= pb0;
    q_b <= pb1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [47:0] act,
                     input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  ctl;
    logic [17:0] a0, a1;
    logic [7:0]  d0, d1;
    logic [47:0] exp;
  } vec_t;

  // ctl = {rst,req0,req1,we0,we1}; f = {gnt0,gnt1,rvalid0,rvalid1}
  // bw = {busy,mem_wren}
  function automatic vec_t v(input logic [4:0] ctl,
                             input logic [17:0] a0, a1,
                             input logic [7:0] d0, d1,
                             input logic [3:0] f,
                             input logic [7:0] q0, q1,
                             input logic [1:0] bw,
                             input logic [17:0] ma,
                             input logic [7:0] md);
    vec_t t;
    t.ctl = ctl;
    t.a0  = a0;
    t.a1  = a1;
    t.d0  = d0;
    t.d1  = d1;
    t.exp = {f, q0, q1, bw, ma, md};
    return t;
  endfunction

  task automatic drive(input logic [4:0] c, input logic [17:0] a0,
                       input logic [17:0] a1, input logic [7:0] d0,
                       input logic [7:0] d1);
    {rst, req0, req1, we0, we1} = c;
    addr0  = a0;
    addr1  = a1;
    wdata0 = d0;
    wdata1 = d1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [32];
  int   na, nb, ca, cb;

  initial begin
    drive(5'b10000, 18'h0, 18'h0, 8'h0, 8'h0);

    tbl[0]  = v(5'b10000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0000, 8'h00, 8'h00, 2'b00, 18'h00000, 8'h00);
    tbl[1]  = v(5'b01010, 18'h20005, 18'h00000, 8'hA5, 8'h00,
                4'b1000, 8'h00, 8'h00, 2'b11, 18'h20005, 8'hA5);
    tbl[2]  = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0000, 8'h00, 8'h00, 2'b00, 18'h20005, 8'hA5);
    tbl[3]  = v(5'b00100, 18'h00000, 18'h20005, 8'h00, 8'h00,
                4'b0100, 8'h00, 8'h00, 2'b10, 18'h20005, 8'h00);
    tbl[4]  = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0000, 8'h00, 8'h00, 2'b10, 18'h20005, 8'h00);
    tbl[5]  = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0001, 8'h00, 8'hA5, 2'b00, 18'h20005, 8'h00);
    tbl[6]  = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0000, 8'h00, 8'hA5, 2'b00, 18'h20005, 8'h00);
    tbl[7]  = v(5'b01111, 18'h0FFFF, 18'h10000, 8'h11, 8'h22,
                4'b1000, 8'h00, 8'hA5, 2'b11, 18'h0FFFF, 8'h11);
    tbl[8]  = v(5'b01111, 18'h0FFFF, 18'h10000, 8'h11, 8'h22,
                4'b0000, 8'h00, 8'hA5, 2'b00, 18'h0FFFF, 8'h11);
    tbl[9]  = v(5'b01111, 18'h0FFFF, 18'h10000, 8'h11, 8'h22,
                4'b0100, 8'h00, 8'hA5, 2'b11, 18'h10000, 8'h22);
    tbl[10] = v(5'b01111, 18'h0FFFF, 18'h10000, 8'h11, 8'h22,
                4'b0000, 8'h00, 8'hA5, 2'b00, 18'h10000, 8'h22);
    tbl[11] = v(5'b01111, 18'h0FFFF, 18'h10000, 8'h11, 8'h22,
                4'b1000, 8'h00, 8'hA5, 2'b11, 18'h0FFFF, 8'h11);
    tbl[12] = v(5'b01111, 18'h0FFFF, 18'h10000, 8'h11, 8'h22,
                4'b0000, 8'h00, 8'hA5, 2'b00, 18'h0FFFF, 8'h11);
    tbl[13] = v(5'b01111, 18'h0FFFF, 18'h10000, 8'h11, 8'h22,
                4'b0100, 8'h00, 8'hA5, 2'b11, 18'h10000, 8'h22);
    tbl[14] = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0000, 8'h00, 8'hA5, 2'b00, 18'h10000, 8'h22);
    tbl[15] = v(5'b01000, 18'h0FFFF, 18'h00000, 8'h00, 8'h00,
                4'b1000, 8'h00, 8'hA5, 2'b10, 18'h0FFFF, 8'h00);
    tbl[16] = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0000, 8'h00, 8'hA5, 2'b10, 18'h0FFFF, 8'h00);
    tbl[17] = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0010, 8'h11, 8'hA5, 2'b00, 18'h0FFFF, 8'h00);
    tbl[18] = v(5'b00100, 18'h00000, 18'h10000, 8'h00, 8'h00,
                4'b0100, 8'h11, 8'hA5, 2'b10, 18'h10000, 8'h00);
    tbl[19] = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0000, 8'h11, 8'hA5, 2'b10, 18'h10000, 8'h00);
    tbl[20] = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0001, 8'h11, 8'h22, 2'b00, 18'h10000, 8'h00);
    tbl[21] = v(5'b01010, 18'h00100, 18'h00000, 8'h5A, 8'h00,
                4'b1000, 8'h11, 8'h22, 2'b11, 18'h00100, 8'h5A);
    tbl[22] = v(5'b00100, 18'h00000, 18'h00100, 8'h00, 8'h00,
                4'b0000, 8'h11, 8'h22, 2'b00, 18'h00100, 8'h5A);
    tbl[23] = v(5'b00100, 18'h00000, 18'h00100, 8'h00, 8'h00,
                4'b0100, 8'h11, 8'h22, 2'b10, 18'h00100, 8'h00);
    tbl[24] = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0000, 8'h11, 8'h22, 2'b10, 18'h00100, 8'h00);
    tbl[25] = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0001, 8'h11, 8'h5A, 2'b00, 18'h00100, 8'h00);
    tbl[26] = v(5'b01000, 18'h20005, 18'h00000, 8'h00, 8'h00,
                4'b1000, 8'h11, 8'h5A, 2'b10, 18'h20005, 8'h00);
    tbl[27] = v(5'b01000, 18'h20005, 18'h00000, 8'h00, 8'h00,
                4'b0000, 8'h11, 8'h5A, 2'b10, 18'h20005, 8'h00);
    tbl[28] = v(5'b11000, 18'h20005, 18'h00000, 8'h00, 8'h00,
                4'b0000, 8'h00, 8'h00, 2'b00, 18'h00000, 8'h00);
    tbl[29] = v(5'b01000, 18'h20005, 18'h00000, 8'h00, 8'h00,
                4'b1000, 8'h00, 8'h00, 2'b10, 18'h20005, 8'h00);
    tbl[30] = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0000, 8'h00, 8'h00, 2'b10, 18'h20005, 8'h00);
    tbl[31] = v(5'b00000, 18'h00000, 18'h00000, 8'h00, 8'h00,
                4'b0010, 8'hA5, 8'h00, 2'b00, 18'h20005, 8'h00);

    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].ctl, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      step();
      chk($sformatf("vec%0d", i),
          {ga0, ga1, va0, va1, qa0, qa1, busy_a, wren_a,
           maddr_a, mdata_a},
          tbl[i].exp);
    end

    // Both requesters held through and after reset.
    drive(5'b11111, 18'h0FFFF, 18'h10000, 8'h11, 8'h22);
    step();
    chk("rst_b", 48'({gb0, gb1, vb0, vb1, busy_b, wren_b}), 48'd0);
    drive(5'b01111, 18'h0FFFF, 18'h10000, 8'h11, 8'h22);
    for (int k = 0; k < 8; k++) begin
      step();
      if (k % 2 == 0) begin
        chk($sformatf("rr_a%0d", k), 48'({ga0, ga1}),
            ((k / 2) % 2 == 0) ? 48'd2 : 48'd1);
        chk($sformatf("fx_b%0d", k), 48'({gb0, gb1}), 48'd2);
      end else begin
        chk($sformatf("gap%0d", k), 48'({ga0, ga1, gb0, gb1}), 48'd0);
      end
    end

    // Write then read on both instances; measure read latency.
    drive(5'b00000, 18'h0, 18'h0, 8'h0, 8'h0);
    repeat (3) step();
    drive(5'b01010, 18'h31234, 18'h0, 8'hC3, 8'h0);
    step();
    chk("wr_c3", 48'({ga0, wren_a, gb0, wren_b}), 48'hF);
    drive(5'b00000, 18'h0, 18'h0, 8'h0, 8'h0);
    repeat (2) step();
    drive(5'b01000, 18'h31234, 18'h0, 8'h0, 8'h0);
    step();
    chk("rd_gnt", 48'({ga0, gb0, wren_a, wren_b}), 48'hC);
    drive(5'b00000, 18'h0, 18'h0, 8'h0, 8'h0);
    na = -1;
    nb = -1;
    ca = 0;
    cb = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (va0) begin
        ca++;
        if (na < 0) na = n;
      end
      if (vb0) begin
        cb++;
        if (nb < 0) nb = n;
      end
    end
    chk("lat_a", 48'(na), 48'd2);
    chk("lat_b", 48'(nb), 48'd4);
    chk("cnt_rv", 48'({ca[7:0], cb[7:0]}), 48'h0101);
    chk("rdata_a", 48'(qa0), 48'hC3);
    chk("rdata_b", 48'(qb0), 48'hC3);
    chk("idle_end", 48'({busy_a, busy_b, va1, vb1}), 48'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 The module SHALL have parameter READ_LATENCY, default 1, giving the clocks from mem_address presentation to valid mem_q; legal range is 1..3.
REQ-002 The module SHALL have parameter FIXED_PRIO, default 0: 0 means round-robin arbitration, 1 means requester 0 always wins.
REQ-003 Port clock, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Ports req0 and req1, input, 1 bit each: access request from requester 0 (core) and requester 1 (loader/DMA).
REQ-006 Ports we0 and we1, input, 1 bit each: 1 means write, 0 means read; held stable with req until gnt.
REQ-007 Ports addr0 and addr1, input, 18 bits each: byte address; bits [17:16] select the bank.
REQ-008 Ports wdata0 and wdata1, input, 8 bits each: write data.
REQ-009 Ports gnt0 and gnt1, output, 1 bit each: one-cycle pulse when the requester's access is issued to memory.
REQ-010 Ports rvalid0 and rvalid1, output, 1 bit each: one-cycle pulse when rdataN holds read data.
REQ-011 Ports rdata0 and rdata1, output, 8 bits each: read data, held until the next read completion for that requester.
REQ-012 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 Port mem_address, output, 18 bits: address to the 256 KB data memory.
REQ-014 Port mem_data, output, 8 bits: write data to memory.
REQ-015 Port mem_wren, output, 1 bit: memory write enable.
REQ-016 Port mem_q, input, 8 bits: memory read data.

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-018 IDLE: if any reqN is high, the arbiter SHALL register the winner's addr, we and wdata into mem_address, mem_data and an internal write flag, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-019 Arbitration when both requests are high: with FIXED_PRIO=0, the requester not granted last SHALL win; with FIXED_PRIO=1, requester 0 SHALL win. When only one request is high, that requester SHALL win.
REQ-020 The last-grant pointer SHALL update only when a grant occurs.
REQ-021 ISSUE (exactly one cycle): gntN SHALL pulse for the winner. mem_wren SHALL equal the write flag in this cycle only.
REQ-022 From ISSUE, a write SHALL return to IDLE; a read SHALL go to WAIT.
REQ-023 WAIT SHALL count READ_LATENCY cycles starting from the ISSUE cycle.
REQ-024 On the final count, mem_q SHALL be captured into rdataN, rvalidN SHALL pulse in the following cycle, and the state SHALL return to IDLE in that same cycle.
REQ-025 Resulting latency: write = 2 clocks from req sampled to gnt/completion; read = req sampled, then gnt at +1, then rvalid at +2+READ_LATENCY.
REQ-026 A reqN high in IDLE SHALL always be treated as a new request. A requester SHALL drop req the cycle after gnt unless it wants another access.
REQ-027 Requests arriving outside IDLE SHALL be ignored until IDLE and SHALL NOT be lost while still held.
REQ-028 mem_address and mem_data SHALL hold their last values while IDLE. mem_wren SHALL never be high outside ISSUE.
REQ-029 At most one gnt, one rvalid and one mem_wren SHALL be active in any cycle.
REQ-030 If a write and a read by different requesters target the same address and are granted back to back, the read SHALL return the newly written data.

Reset
REQ-031 While reset is high at a clock edge, the block SHALL go to IDLE with the last-grant pointer set to requester 1, so requester 0 wins the first tie.
REQ-032 While reset is high, all outputs SHALL be 0: gnt, rvalid, rdata, busy, mem_address, mem_data and mem_wren.
REQ-033 Reset asserted mid-access SHALL abort that access: no rvalid SHALL follow, and mem_wren SHALL be low from the next edge.
REQ-034 Requests held high through reset SHALL be arbitrated in the first cycle after reset deasserts.

Verification
REQ-035 Single write: req0=1, we0=1, addr0=18'h2_0005, wdata0=8'hA5 -> gnt0 pulses 1 cycle later with mem_wren=1, mem_address=18'h2_0005, mem_data=8'hA5; busy is low the following cycle.
REQ-036 Read-back with READ_LATENCY=1: after REQ-035, req1=1, we1=0, addr1=18'h2_0005 -> gnt1 at +1, rvalid1 at +3, rdata1=8'hA5; rvalid0 stays 0.
REQ-037 Round-robin: req0 and req1 held high continuously with FIXED_PRIO=0 -> grants alternate 0,1,0,1 starting with 0 after reset; with FIXED_PRIO=1 -> grants are all gnt0.
REQ-038 Bank boundary: write 8'h11 to 18'h0_FFFF and 8'h22 to 18'h1_0000, then read both -> 8'h11 and 8'h22 respectively, with no aliasing.
REQ-039 Reset mid-read: assert reset in the WAIT state -> no rvalid pulse, busy=0 and mem_wren=0 after the edge, and a held req0 is granted 1 cycle after reset deasserts.
REQ-040 Latency sweep: READ_LATENCY=3 -> rvalid arrives 5 cycles after req is sampled, and rdata matches the stored value.
